// File: rtl/demux_1_8_deser.sv
// ---------------------------------------------------------------------------
// demux_1_8_deser
//
// Serial-to-parallel deserializer: the receive-side counterpart of the 8:1
// mux serializer path. A slot counter acts as the select of a 1:WIDTH demux
// and steers each accepted serial bit into one position of a staging
// register. When the last position is filled, the word moves to y_out and is
// offered on a valid/ready interface. Backpressure from the consumer is
// reflected onto the serial input through bit_ready.
//
// Parameters
//   WIDTH      output word width, power of two, >= 2
//   CNT_W      slot counter width, must equal log2(WIDTH)
//
// Ports
//   clk        rising-edge clock, single clock domain
//   rst        synchronous active-high reset
//   bit_in     serial data bit
//   bit_valid  bit_in is valid this cycle
//   bit_ready  block can accept a bit this cycle (combinational)
//   y_out      assembled word, stable while out_valid is high
//   out_valid  y_out holds a complete word
//   out_ready  consumer takes y_out this cycle
//   slot       raw demux select, i.e. the position index of the next bit
//
// Build option
//   DEMUX_DESER_MSB_FIRST_EN  when defined, the first received bit lands in
//                             y_out[WIDTH-1] instead of y_out[0]. The slot
//                             port reports the raw counter in both builds.
// ---------------------------------------------------------------------------
module demux_1_8_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] slot
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_SLOT  = CNT_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   staging;
    logic [WIDTH-1:0]   staging_merged;
    logic [CNT_W-1:0]   wr_pos;
    logic               accept;

    // Ready depends only on our own state and the consumer's ready, never on
    // bit_valid, so there is no combinational valid->ready path on the input.
    assign bit_ready = (state == COLLECT) || out_ready;
    assign accept    = bit_valid && bit_ready;

    // Demux select to bit position. In FULL the counter is always 0, so the
    // same mapping also places a bit accepted during the hand-off correctly.
`ifdef DEMUX_DESER_MSB_FIRST_EN
    assign wr_pos = LAST_SLOT - slot;
`else
    assign wr_pos = slot;
`endif

    // Staging register with the incoming bit already merged in, so the last
    // bit of a word can go straight to y_out on the same edge it is accepted.
    always_comb begin
        staging_merged         = staging;
        staging_merged[wr_pos] = bit_in;
    end

    // Main control: slot counter, staging register and registered output.
    // The staging register is cleared whenever a word moves to y_out so that
    // positions of the next word can never inherit bits from the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            staging   <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            slot      <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (slot == LAST_SLOT) begin
                            y_out     <= staging_merged;
                            out_valid <= 1'b1;
                            staging   <= '0;
                            slot      <= '0;
                            state     <= FULL;
                        end else begin
                            staging <= staging_merged;
                            slot    <= slot + ONE_SLOT;
                        end
                    end
                end

                FULL: begin
                    // Word is held until taken; a bit arriving in the same
                    // cycle as the take starts the next word without a bubble.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= COLLECT;
                        if (bit_valid) begin
                            staging <= staging_merged;
                            slot    <= ONE_SLOT;
                        end
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
